seq_det_arbiter: RTL and testbench

SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

---
 rtl/seq_det_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_seq_det_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter.sv
// ---------------------------------------------------------------------------
// seq_det_arbiter
//
// Purpose:
//   Round-robin arbiter over four serial bit streams. At most one channel is
//   granted at a time. Each channel has its own "two or more consecutive 1s"
//   detector context. Only the granted channel may advance its context.
//   Contexts persist across grants, so a run of 1s that straddles two bursts
//   is still detected.
//
// Parameters:
//   BURST     maximum number of bits consumed per grant (1..255)
//
// Ports:
//   clk       single clock, rising-edge active
//   rst       asynchronous active-high reset
//   req[3:0]  per-channel request to stream bits
//   w[3:0]    per-channel serial data bit
//   w_vld[3:0] per-channel data-valid qualifier for w
//   clr_ctx   synchronous clear of all detector contexts to A
//   gnt[3:0]  registered one-hot grant, zero while idle
//   match     registered one-cycle pulse on a detection
//   match_ch  channel that produced the last match (holds between pulses)
//   hit_cnt   saturating count of match pulses
// ---------------------------------------------------------------------------
module seq_det_arbiter #(
  parameter int unsigned BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  w,
  input  logic [3:0]  w_vld,
  input  logic        clr_ctx,
  output logic [3:0]  gnt,
  output logic        match,
  output logic [1:0]  match_ch,
  output logic [15:0] hit_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CTX_A = 2'b00,
    CTX_B = 2'b01,
    CTX_C = 2'b10
  } ctx_e;

  localparam logic [7:0]  BURST_LAST = 8'(BURST);
  localparam logic [15:0] HIT_MAX    = 16'hFFFF;

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic [1:0]  last_gnt_q, last_gnt_d;
  logic [7:0]  beat_q, beat_d;
  ctx_e        ctx_q [4];
  ctx_e        ctx_d [4];
  logic        match_q, match_d;
  logic [1:0]  match_ch_q, match_ch_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;

  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic        consume;
  logic        cur_w;
  ctx_e        cur_ctx;
  logic [7:0]  beat_inc;
  logic        burst_done;

  // Round-robin pick: scan upward from the channel after the last grant.
  // The 2-bit index wraps naturally, and k=4 lands back on last_gnt itself,
  // so a lone requester is always found.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_gnt_q;
    for (int k = 1; k <= 4; k++) begin
      if (!pick_vld && req[last_gnt_q + 2'(k)]) begin
        pick_vld = 1'b1;
        pick_idx = last_gnt_q + 2'(k);
      end
    end
  end

  // A bit is taken only from the granted channel, and only while granted.
  assign consume    = (state_q == GRANT) && w_vld[gnt_idx_q];
  assign cur_w      = w[gnt_idx_q];
  assign cur_ctx    = ctx_q[gnt_idx_q];
  assign beat_inc   = beat_q + 8'd1;
  assign burst_done = consume && (beat_inc == BURST_LAST);

  // Arbiter next-state. Leaving GRANT always passes through one IDLE cycle,
  // which gives the mandatory gnt=0 gap between bursts.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    last_gnt_d = last_gnt_q;
    beat_d     = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_idx;
          gnt_d      = 4'(4'b0001 << pick_idx);
          last_gnt_d = pick_idx;
          beat_d     = 8'd0;
        end
      end
      GRANT: begin
        if (consume) begin
          beat_d = beat_inc;
        end
        if (burst_done || !req[gnt_idx_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Detector contexts. clr_ctx wins over a simultaneous consumption, which
  // also suppresses the match that bit would otherwise have produced. The
  // beat counter still advances because the bit was taken from the stream.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ctx_d[i] = ctx_q[i];
    end
    match_d    = 1'b0;
    match_ch_d = match_ch_q;
    if (clr_ctx) begin
      for (int i = 0; i < 4; i++) begin
        ctx_d[i] = CTX_A;
      end
    end else if (consume) begin
      if (!cur_w) begin
        ctx_d[gnt_idx_q] = CTX_A;
      end else begin
        case (cur_ctx)
          CTX_A: ctx_d[gnt_idx_q] = CTX_B;
          CTX_B, CTX_C: begin
            ctx_d[gnt_idx_q] = CTX_C;
            match_d          = 1'b1;
            match_ch_d       = gnt_idx_q;
          end
          default: ctx_d[gnt_idx_q] = CTX_A;
        endcase
      end
    end
  end

  // Hit counter advances together with the match pulse and sticks at max.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (match_d && (hit_cnt_q != HIT_MAX)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
  end

  // State registers. last_gnt resets to 3 so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_idx_q  <= 2'd0;
      last_gnt_q <= 2'd3;
      beat_q     <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        ctx_q[i] <= CTX_A;
      end
      match_q    <= 1'b0;
      match_ch_q <= 2'd0;
      hit_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      last_gnt_q <= last_gnt_d;
      beat_q     <= beat_d;
      for (int i = 0; i < 4; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
      match_q    <= match_d;
      match_ch_q <= match_ch_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign match    = match_q;
  assign match_ch = match_ch_q;
  assign hit_cnt  = hit_cnt_q;

  // Grant is one-hot or zero, and zero exactly when the arbiter is idle.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_gnt_idle:    assert property (@(posedge clk) disable iff (rst)
                                  ((state_q == IDLE) == (gnt_q == 4'b0000)));

endmodule

// File: tb/tb_seq_det_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_det_arbiter
//
// Purpose:
//   Self-checking bench for seq_det_arbiter. It uses a main instance with
//   BURST=8 and a second instance with BURST=255 that is driven into hit
//   counter saturation. The reference model tracks each channel's run length
//   of consecutive 1s and a simple owner/beats view of the arbiter.
// ---------------------------------------------------------------------------
module tb_seq_det_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, w, w_vld;
  logic        clr_ctx;
  logic [3:0]  gnt;
  logic        match;
  logic [1:0]  match_ch;
  logic [15:0] hit_cnt;

  logic        sat_rst;
  logic [3:0]  sat_gnt;
  logic        sat_match;
  logic [1:0]  sat_match_ch;
  logic [15:0] sat_hit_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_arbiter #(.BURST(8)) dut (
    .clk(clk), .rst(rst), .req(req), .w(w), .w_vld(w_vld), .clr_ctx(clr_ctx),
    .gnt(gnt), .match(match), .match_ch(match_ch), .hit_cnt(hit_cnt)
  );

  seq_det_arbiter #(.BURST(255)) dut_sat (
    .clk(clk), .rst(sat_rst), .req(4'b0001), .w(4'b0001), .w_vld(4'b0001),
    .clr_ctx(1'b0), .gnt(sat_gnt), .match(sat_match), .match_ch(sat_match_ch),
    .hit_cnt(sat_hit_cnt)
  );

  // Reference model: the owner, beats taken, and run length of 1s per channel
  typedef struct {
    bit busy;
    int owner;
    int last;
    int beats;
    int run [4];
    bit m;
    int mch;
    int hits;
  } model_t;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  w;
    logic [3:0]  vld;
    logic        clr;
    logic [3:0]  gnt;
    logic        m;
    logic [1:0]  mch;
    logic [15:0] hit;
  } vec_t;

  function automatic model_t modelReset();
    model_t r;
    r.busy  = 1'b0;
    r.owner = 0;
    r.last  = 3;
    r.beats = 0;
    for (int i = 0; i < 4; i++) r.run[i] = 0;
    r.m     = 1'b0;
    r.mch   = 0;
    r.hits  = 0;
    return r;
  endfunction

  function automatic model_t modelStep(model_t s, logic [3:0] rq, logic [3:0] wb,
                                       logic [3:0] vd, logic clr, int burst);
    model_t n;
    int o;
    n   = s;
    n.m = 1'b0;
    if (!s.busy) begin
      for (int k = 1; k <= 4; k++) begin
        if (!n.busy && rq[(s.last + k) % 4]) begin
          n.busy  = 1'b1;
          n.owner = (s.last + k) % 4;
          n.last  = n.owner;
          n.beats = 0;
        end
      end
    end else begin
      o = s.owner;
      if (vd[o]) begin
        n.beats = s.beats + 1;
        if (!clr) begin
          if (wb[o]) begin
            if (s.run[o] >= 1) begin
              n.m   = 1'b1;
              n.mch = o;
              if (s.hits < 65535) n.hits = s.hits + 1;
            end
            n.run[o] = s.run[o] + 1;
          end else begin
            n.run[o] = 0;
          end
        end
      end
      if ((vd[o] && n.beats == burst) || !rq[o]) n.busy = 1'b0;
    end
    if (clr) for (int i = 0; i < 4; i++) n.run[i] = 0;
    return n;
  endfunction

  function automatic logic [3:0] modelGnt(model_t s);
    return s.busy ? 4'(4'b0001 << s.owner) : 4'b0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rq, input logic [3:0] wb,
                               input logic [3:0] vd, input logic clr);
    req     = rq;
    w       = wb;
    w_vld   = vd;
    clr_ctx = clr;
  endtask

  task automatic checkAgainstModel(input string tag, input model_t s);
    checkOutput({tag, "_gnt"},      32'(gnt),      32'(modelGnt(s)));
    checkOutput({tag, "_match"},    32'(match),    32'(s.m));
    checkOutput({tag, "_match_ch"}, 32'(match_ch), 32'(s.mch));
    checkOutput({tag, "_hit_cnt"},  32'(hit_cnt),  32'(s.hits));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_gnt"},      32'(gnt),      32'd0);
    checkOutput({tag, "_match"},    32'(match),    32'd0);
    checkOutput({tag, "_match_ch"}, 32'(match_ch), 32'd0);
    checkOutput({tag, "_hit_cnt"},  32'(hit_cnt),  32'd0);
  endtask

  // Called right after a falling edge; holds reset across one rising edge.
  task automatic doReset(input string tag);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkZero(tag);
    rst = 1'b0;
  endtask

  task automatic runTable();
    vec_t tbl [14];
    tbl[0]  = '{4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{4'h4, 4'h0, 4'h4, 1'b0, 4'h4, 1'b0, 2'd0, 16'd0};
    tbl[2]  = '{4'h4, 4'h4, 4'h4, 1'b0, 4'h4, 1'b0, 2'd0, 16'd0};
    tbl[3]  = '{4'h4, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 16'd1};
    tbl[4]  = '{4'h4, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 16'd2};
    tbl[5]  = '{4'h4, 4'h0, 4'h4, 1'b0, 4'h4, 1'b0, 2'd2, 16'd2};
    tbl[6]  = '{4'h4, 4'h4, 4'h4, 1'b0, 4'h4, 1'b0, 2'd2, 16'd2};
    tbl[7]  = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2, 16'd2};
    tbl[8]  = '{4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 2'd2, 16'd2};
    tbl[9]  = '{4'h4, 4'h4, 4'h4, 1'b1, 4'h4, 1'b0, 2'd2, 16'd2};
    tbl[10] = '{4'h4, 4'h4, 4'h4, 1'b0, 4'h4, 1'b0, 2'd2, 16'd2};
    tbl[11] = '{4'h4, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 16'd3};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2, 16'd3};
    tbl[13] = '{4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 2'd2, 16'd3};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].req, tbl[i].w, tbl[i].vld, tbl[i].clr);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_gnt", i),      32'(gnt),      32'(tbl[i].gnt));
      checkOutput($sformatf("tbl%0d_match", i),    32'(match),    32'(tbl[i].m));
      checkOutput($sformatf("tbl%0d_match_ch", i), 32'(match_ch), 32'(tbl[i].mch));
      checkOutput($sformatf("tbl%0d_hit_cnt", i),  32'(hit_cnt),  32'(tbl[i].hit));
    end
    // Reset arrives with a bit that would match: outputs clear with no edge.
    applyStimulus(4'h4, 4'h4, 4'h4, 1'b0);
    rst = 1'b1;
    #1;
    checkZero("async_rst");
    @(negedge clk);
    checkZero("rst_no_match");
    rst = 1'b0;
  endtask

  task automatic runRotation();
    logic [3:0] expGnt;
    applyStimulus(4'b1111, 4'b0000, 4'b1111, 1'b0);
    for (int s = 0; s < 45; s++) begin
      @(negedge clk);
      expGnt = ((s % 9) < 8) ? 4'(4'b0001 << ((s / 9) % 4)) : 4'b0000;
      checkOutput($sformatf("rot%0d_gnt", s), 32'(gnt), 32'(expGnt));
    end
  endtask

  task automatic runCarry();
    logic [3:0] expGnt;
    for (int c = 0; c < 21; c++) begin
      applyStimulus(4'b0011, {3'b000, (c == 8 || c == 19)}, 4'b0011, 1'b0);
      @(negedge clk);
      if (c <= 7 || c >= 18)  expGnt = 4'b0001;
      else if (c >= 9 && c <= 16) expGnt = 4'b0010;
      else expGnt = 4'b0000;
      checkOutput($sformatf("carry%0d_gnt", c),   32'(gnt),     32'(expGnt));
      checkOutput($sformatf("carry%0d_match", c), 32'(match),   32'(c == 19));
      checkOutput($sformatf("carry%0d_hit", c),   32'(hit_cnt), 32'(c >= 19));
    end
    checkOutput("carry_match_ch", 32'(match_ch), 32'd0);
  endtask

  task automatic runDrop();
    logic [3:0] rq  [9] = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h4, 4'h4, 4'h2, 4'h2, 4'h2};
    logic [3:0] wb  [9] = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0, 4'h2};
    logic [3:0] vd  [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'hB, 4'h0, 4'h2};
    logic [3:0] eg  [9] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0, 4'h2, 4'h2};
    for (int c = 0; c < 9; c++) begin
      applyStimulus(rq[c], wb[c], vd[c], 1'b0);
      @(negedge clk);
      checkOutput($sformatf("drop%0d_gnt", c),      32'(gnt),      32'(eg[c]));
      checkOutput($sformatf("drop%0d_match", c),    32'(match),    32'(c == 8));
      checkOutput($sformatf("drop%0d_match_ch", c), 32'(match_ch), (c == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("drop_hit", 32'(hit_cnt), 32'd1);
  endtask

  task automatic runRandom();
    model_t     m;
    logic [3:0] rq, wb, vd;
    logic       clr;
    m = modelReset();
    for (int c = 0; c < 3000; c++) begin
      checkAgainstModel($sformatf("rnd%0d", c), m);
      rq  = 4'($urandom) | 4'($urandom);
      wb  = 4'($urandom);
      vd  = 4'($urandom) | 4'($urandom);
      clr = ($urandom_range(31) == 0);
      applyStimulus(rq, wb, vd, clr);
      if ($urandom_range(255) == 0) begin
        rst = 1'b1;
        #1;
        checkZero($sformatf("rnd%0d_rst", c));
        m = modelReset();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        m = modelStep(m, rq, wb, vd, clr, 8);
        @(negedge clk);
      end
    end
  endtask

  task automatic runSaturation();
    model_t ms;
    int     tm;
    bit     reached;
    ms      = modelReset();
    tm      = 0;
    reached = 1'b0;
    sat_rst = 1'b0;
    for (int cyc = 0; cyc < 70000 && !reached; cyc++) begin
      if (ms.hits >= 65530 || (cyc % 8192) == 0) begin
        checkOutput($sformatf("sat%0d_gnt", cyc),   32'(sat_gnt),     32'(modelGnt(ms)));
        checkOutput($sformatf("sat%0d_match", cyc), 32'(sat_match),   32'(ms.m));
        checkOutput($sformatf("sat%0d_hit", cyc),   32'(sat_hit_cnt), 32'(ms.hits));
      end
      ms = modelStep(ms, 4'b0001, 4'b0001, 4'b0001, 1'b0, 255);
      if (ms.m) tm++;
      @(negedge clk);
      if (tm >= 65537) reached = 1'b1;
    end
    checkOutput("sat_hold_hit",   32'(sat_hit_cnt), 32'h0000FFFF);
    checkOutput("sat_hold_match", 32'(sat_match),   32'(ms.m));
    checkOutput("sat_hold_gnt",   32'(sat_gnt),     32'(modelGnt(ms)));
    // Mid-burst reset clears every output without waiting for an edge.
    sat_rst = 1'b1;
    #1;
    checkOutput("sat_rst_gnt",      32'(sat_gnt),      32'd0);
    checkOutput("sat_rst_match",    32'(sat_match),    32'd0);
    checkOutput("sat_rst_match_ch", 32'(sat_match_ch), 32'd0);
    checkOutput("sat_rst_hit",      32'(sat_hit_cnt),  32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    sat_rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    doReset("reset_table");
    runTable();
    doReset("reset_rot");
    runRotation();
    doReset("reset_carry");
    runCarry();
    doReset("reset_drop");
    runDrop();
    doReset("reset_rnd");
    runRandom();
    runSaturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
